// File: rtl/gc_host_poller.sv
// GameCube controller host: sends a 1..3 byte command on the open-drain data line, then collects the reply.
// Optional build macro GC_HOST_GLITCH_FILTER_EN adds a 3-sample majority filter after the synchronizer.
module gc_host_poller #(
    parameter int US_CYCLES  = 40,
    parameter int TIMEOUT_US = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_start,
    input  logic [23:0] cmd_data,
    input  logic [1:0]  cmd_len,
    input  logic [6:0]  rsp_len,
    input  logic        bus_in,
    output logic        bus_oe,
    output logic        busy,
    output logic [79:0] rsp_data,
    output logic [6:0]  rsp_bits,
    output logic        rsp_valid,
    output logic        timeout
);
    localparam int TW = $clog2(TIMEOUT_US * US_CYCLES + 4 * US_CYCLES + 1);
    localparam logic [TW-1:0] T_1US    = TW'(US_CYCLES);
    localparam logic [TW-1:0] T_3US    = TW'(3 * US_CYCLES);
    localparam logic [TW-1:0] T_5US    = TW'(5 * US_CYCLES);
    localparam logic [TW-1:0] T_1US_M1 = TW'(US_CYCLES - 1);
    localparam logic [TW-1:0] T_2US_M1 = TW'(2 * US_CYCLES - 1);
    localparam logic [TW-1:0] T_4US_M1 = TW'(4 * US_CYCLES - 1);
    localparam logic [TW-1:0] T_TO_M1  = TW'(TIMEOUT_US * US_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, TX_BIT, TX_STOP, RX_WAIT, RX_BIT, DONE} state_t;

    state_t        state, state_nx;
    logic [1:0]    sync;
    logic          bus_f, bus_d, fall;
    logic [TW-1:0] tmr;
    logic [23:0]   tx_sr;
    logic [4:0]    bit_cnt, bit_last;
    logic [6:0]    len_q;
    logic          stop_q, smp_done;
    logic          accept, bit_end, smp_now, stuck;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync <= 2'b11;
        else       sync <= {sync[0], bus_in};
    end

`ifdef GC_HOST_GLITCH_FILTER_EN
    logic [2:0] flt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) flt <= 3'b111;
        else       flt <= {flt[1:0], sync[1]};
    end

    assign bus_f = (flt[0] & flt[1]) | (flt[0] & flt[2]) | (flt[1] & flt[2]);
`else
    assign bus_f = sync[1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus_d <= 1'b1;
        else       bus_d <= bus_f;
    end

    assign fall    = bus_d & ~bus_f;
    assign accept  = (state == IDLE) && cmd_start;
    assign bit_end = (state == TX_BIT) && (tmr == T_4US_M1);
    assign smp_now = (state == RX_BIT) && !stop_q && !smp_done && (tmr == T_2US_M1);
    // Any low phase longer than 5 us is a stuck line, data or stop bit alike.
    assign stuck   = (state == RX_BIT) && !bus_f && (tmr >= T_5US);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_start) state_nx = TX_BIT;
            TX_BIT:  if (bit_end && (bit_cnt == bit_last)) state_nx = TX_STOP;
            TX_STOP: if (tmr == T_1US_M1) state_nx = (len_q == 7'd0) ? DONE : RX_WAIT;
            RX_WAIT: begin
                if (fall)                  state_nx = RX_BIT;
                else if (tmr == T_TO_M1)   state_nx = IDLE;
            end
            RX_BIT: begin
                if (stuck)                 state_nx = IDLE;
                else if (bus_f && stop_q)  state_nx = DONE;
                else if (bus_f && smp_done) state_nx = RX_WAIT;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus_oe    = 1'b0;
        rsp_valid = 1'b0;
        timeout   = 1'b0;
        case (state)
            TX_BIT:  bus_oe = tx_sr[23] ? (tmr < T_1US) : (tmr < T_3US);
            TX_STOP: bus_oe = 1'b1;
            RX_WAIT: timeout = !fall && (tmr == T_TO_M1);
            RX_BIT:  timeout = stuck;
            DONE:    rsp_valid = 1'b1;
            default: ;
        endcase
        busy = (state != IDLE) && (state != DONE) && !timeout;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr      <= '0;
            tx_sr    <= '0;
            bit_cnt  <= '0;
            bit_last <= '0;
            len_q    <= '0;
            stop_q   <= 1'b0;
            smp_done <= 1'b0;
            rsp_data <= '0;
            rsp_bits <= '0;
        end else begin
            // One timer serves bit timing, sample point and both watchdogs; it restarts on every state change.
            if ((state_nx != state) || bit_end) tmr <= '0;
            else if (state != IDLE)              tmr <= tmr + 1'b1;

            if (accept) begin
                tx_sr    <= cmd_data;
                bit_cnt  <= '0;
                bit_last <= (cmd_len == 2'd0) ? 5'd7 : {cmd_len - 2'd1, 3'b111};
                len_q    <= (rsp_len > 7'd80) ? 7'd80 : rsp_len;
                rsp_data <= '0;
                rsp_bits <= '0;
            end

            if (bit_end) begin
                tx_sr   <= {tx_sr[22:0], 1'b0};
                bit_cnt <= bit_cnt + 1'b1;
            end

            // The edge after the last expected data bit is the controller stop bit.
            if ((state == RX_WAIT) && fall) begin
                stop_q   <= (rsp_bits == len_q);
                smp_done <= 1'b0;
            end

            if (smp_now) begin
                rsp_data <= {rsp_data[78:0], bus_f};
                rsp_bits <= rsp_bits + 1'b1;
                smp_done <= 1'b1;
            end
        end
    end
endmodule
